// File: rtl/btb_update_gen.sv
// BTB update command generator: compares resolved control flow against the fetch-time
// prediction, emits one registered BTB update plus redirect, and squashes wrong-path results.
// Optional perf counters are enabled by defining BTB_UPD_PERF_CNT_EN.
module btb_update_gen #(
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             res_valid,
   input  logic [31:0]      res_pc,
   input  logic             res_is_br,
   input  logic             res_is_call,
   input  logic             res_is_ret,
   input  logic             act_taken,
   input  logic [31:0]      act_target,
   input  logic             pred_hit,
   input  logic             pred_taken,
   input  logic [31:0]      pred_target,
   input  logic [IDX_W-1:0] pred_index,
   input  logic             flush_in,
   output logic             operate_en,
   output logic [31:0]      operate_pc,
   output logic [IDX_W-1:0] operate_index,
   output logic             add_entry,
   output logic             delete_entry,
   output logic             pre_error,
   output logic             pre_right,
   output logic             target_error,
   output logic             right_orien,
   output logic [31:0]      right_target,
   output logic             push_ras,
   output logic             pop_ras,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc
`ifdef BTB_UPD_PERF_CNT_EN
   ,
   output logic [31:0]      perf_br_cnt,
   output logic [31:0]      perf_mis_cnt,
   output logic [31:0]      perf_squash_cnt
`endif
);

   typedef enum logic {S_IDLE, S_SQUASH} state_t;

   state_t      r_state;
   logic [31:0] r_expect_pc;

   logic        w_accept;
   logic        w_dropped;
   logic        w_nbr_hit;
   logic        w_add;
   logic        w_br_hit;
   logic        w_dir_err;
   logic        w_dir_ok;
   logic        w_tgt_err;
   logic        w_push;
   logic        w_pop;
   logic        w_cmd;
   logic        w_redir;
   logic [31:0] w_pc4;
   logic [31:0] w_redir_pc;

   always_comb begin
      // NOTE: always_comb assigns every signal unconditionally so no latch can be inferred.
      w_accept   = res_valid & ~flush_in & ((r_state == S_IDLE) | (res_pc == r_expect_pc));
      w_dropped  = res_valid & ~w_accept;
      w_nbr_hit  = ~res_is_br & pred_hit;
      w_add      = res_is_br & ~pred_hit & act_taken;
      w_br_hit   = res_is_br & pred_hit;
      w_dir_err  = w_br_hit & (pred_taken != act_taken);
      w_dir_ok   = w_br_hit & (pred_taken == act_taken);
      // Targets are word aligned, so the low two bits never distinguish them.
      w_tgt_err  = w_br_hit & act_taken & pred_taken & (pred_target[31:2] != act_target[31:2]);
      w_push     = res_is_call & act_taken;
      w_pop      = res_is_ret;
      w_cmd      = w_nbr_hit | w_add | w_br_hit | w_push | w_pop;
      w_redir    = (w_nbr_hit & pred_taken) | w_add | w_dir_err | w_tgt_err;
      w_pc4      = res_pc + 32'd4;
      w_redir_pc = (~res_is_br | ~act_taken) ? w_pc4 : act_target;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_expect_pc    <= '0;
         operate_en     <= 1'b0;
         operate_pc     <= '0;
         operate_index  <= '0;
         add_entry      <= 1'b0;
         delete_entry   <= 1'b0;
         pre_error      <= 1'b0;
         pre_right      <= 1'b0;
         target_error   <= 1'b0;
         right_orien    <= 1'b0;
         right_target   <= '0;
         push_ras       <= 1'b0;
         pop_ras        <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples
         // pre-edge values; the defaults below make every strobe single-cycle.
         operate_en     <= 1'b0;
         operate_pc     <= '0;
         operate_index  <= '0;
         add_entry      <= 1'b0;
         delete_entry   <= 1'b0;
         pre_error      <= 1'b0;
         pre_right      <= 1'b0;
         target_error   <= 1'b0;
         right_orien    <= 1'b0;
         right_target   <= '0;
         push_ras       <= 1'b0;
         pop_ras        <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         if (w_accept && w_cmd) begin
            operate_en     <= 1'b1;
            operate_pc     <= res_pc;
            operate_index  <= pred_hit ? pred_index : '0;
            add_entry      <= w_add;
            delete_entry   <= w_nbr_hit;
            pre_error      <= w_dir_err;
            pre_right      <= w_dir_ok;
            target_error   <= w_tgt_err;
            right_orien    <= act_taken;
            right_target   <= act_target;
            push_ras       <= w_push;
            pop_ras        <= w_pop;
            redirect_valid <= w_redir;
            redirect_pc    <= w_redir ? w_redir_pc : '0;
         end
         if (flush_in) begin
            r_state <= S_IDLE;
         end else if (w_accept) begin
            r_state <= w_redir ? S_SQUASH : S_IDLE;
            if (w_redir) r_expect_pc <= w_redir_pc;
         end
      end
   end

`ifdef BTB_UPD_PERF_CNT_EN
   // Saturating counters: they stick at all-ones rather than wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_br_cnt     <= '0;
         perf_mis_cnt    <= '0;
         perf_squash_cnt <= '0;
      end else begin
         if (w_accept && res_is_br && perf_br_cnt != '1)
            perf_br_cnt <= perf_br_cnt + 32'd1;
         if (w_accept && res_is_br && w_redir && perf_mis_cnt != '1)
            perf_mis_cnt <= perf_mis_cnt + 32'd1;
         if (w_dropped && perf_squash_cnt != '1)
            perf_squash_cnt <= perf_squash_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_btb_update_gen.sv
// Directed scoreboard bench for btb_update_gen: stimulus pushes hand-computed expected
// commands, a negedge monitor pops and compares whenever the DUT emits a command or redirect.
module tb_btb_update_gen;

   typedef struct packed {
      logic        op_en;
      logic [31:0] op_pc;
      logic [4:0]  idx;
      logic        add;
      logic        del;
      logic        perr;
      logic        pright;
      logic        terr;
      logic        orien;
      logic [31:0] rtgt;
      logic        push;
      logic        pop;
      logic        rv;
      logic [31:0] rpc;
   } out_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = '0;
   logic        res_is_br = 1'b0;
   logic        res_is_call = 1'b0;
   logic        res_is_ret = 1'b0;
   logic        act_taken = 1'b0;
   logic [31:0] act_target = '0;
   logic        pred_hit = 1'b0;
   logic        pred_taken = 1'b0;
   logic [31:0] pred_target = '0;
   logic [4:0]  pred_index = '0;
   logic        flush_in = 1'b0;

   logic        operate_en;
   logic [31:0] operate_pc;
   logic [4:0]  operate_index;
   logic        add_entry, delete_entry, pre_error, pre_right, target_error, right_orien;
   logic [31:0] right_target;
   logic        push_ras, pop_ras, redirect_valid;
   logic [31:0] redirect_pc;

   int   total = 0;
   int   bad = 0;
   bit   mon_on = 1'b0;
   out_t exp_q[$];

   btb_update_gen #(.IDX_W(5)) dut (
      .clk(clk), .reset(reset), .res_valid(res_valid), .res_pc(res_pc),
      .res_is_br(res_is_br), .res_is_call(res_is_call), .res_is_ret(res_is_ret),
      .act_taken(act_taken), .act_target(act_target), .pred_hit(pred_hit),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index),
      .flush_in(flush_in), .operate_en(operate_en), .operate_pc(operate_pc),
      .operate_index(operate_index), .add_entry(add_entry), .delete_entry(delete_entry),
      .pre_error(pre_error), .pre_right(pre_right), .target_error(target_error),
      .right_orien(right_orien), .right_target(right_target), .push_ras(push_ras),
      .pop_ras(pop_ras), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef BTB_UPD_PERF_CNT_EN
      , .perf_br_cnt(), .perf_mis_cnt(), .perf_squash_cnt()
`endif
   );

   always #5 clk = ~clk;

   function automatic out_t actual();
      out_t a;
      a = '{operate_en, operate_pc, operate_index, add_entry, delete_entry, pre_error,
            pre_right, target_error, right_orien, right_target, push_ras, pop_ras,
            redirect_valid, redirect_pc};
      return a;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected command per DUT command/redirect.
   always @(negedge clk) begin
      out_t a;
      a = actual();
      if (mon_on && (a.op_en === 1'b1 || a.rv === 1'b1)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_cmd: got %h expected no command", a);
         end else begin
            check("cmd", a, exp_q.pop_front());
         end
      end
   end

   function automatic out_t mk(input logic [31:0] pc, input logic [4:0] idx,
                               input logic add, del, perr, pright, terr, orien,
                               input logic [31:0] rtgt, input logic push, pop, rv,
                               input logic [31:0] rpc);
      out_t e;
      e = '{1'b1, pc, idx, add, del, perr, pright, terr, orien, rtgt, push, pop, rv, rpc};
      return e;
   endfunction

   task automatic send(input logic [31:0] pc, input logic br, call, ret, at,
                       input logic [31:0] atgt, input logic ph, pt,
                       input logic [31:0] ptgt, input logic [4:0] pidx, input logic fl);
      @(negedge clk);
      res_valid = 1'b1; res_pc = pc; res_is_br = br; res_is_call = call; res_is_ret = ret;
      act_taken = at; act_target = atgt; pred_hit = ph; pred_taken = pt;
      pred_target = ptgt; pred_index = pidx; flush_in = fl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         res_valid = 1'b0; flush_in = 1'b0; reset = 1'b0;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_state", actual(), '0);
      mon_on = 1'b1;

      // Fresh entry, then the wrong-path squash window.
      send(32'h1C000100, 1, 0, 0, 1, 32'h1C000200, 0, 0, 32'h0, 5'd0, 0);
      exp_q.push_back(mk(32'h1C000100, 5'd0, 1, 0, 0, 0, 0, 1, 32'h1C000200, 0, 0, 1, 32'h1C000200));
      send(32'h1C000104, 1, 0, 0, 1, 32'h1C000900, 1, 0, 32'h0, 5'd1, 0);
      send(32'h1C000108, 0, 0, 0, 0, 32'h0, 1, 1, 32'h0, 5'd2, 0);
      send(32'h1C000200, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 5'd0, 0);

      // Direction miss (also shows the squash ended: this pc is arbitrary).
      send(32'h1C000300, 1, 0, 0, 0, 32'h1C000380, 1, 1, 32'h1C000380, 5'd7, 0);
      exp_q.push_back(mk(32'h1C000300, 5'd7, 0, 0, 1, 0, 0, 0, 32'h1C000380, 0, 0, 1, 32'h1C000304));

      // Target error on a return, redirected again inside the squash window.
      send(32'h1C000304, 1, 0, 1, 1, 32'h1C000480, 1, 1, 32'h1C000400, 5'd3, 0);
      exp_q.push_back(mk(32'h1C000304, 5'd3, 0, 0, 0, 1, 1, 1, 32'h1C000480, 0, 1, 1, 32'h1C000480));

      // Correctly predicted call.
      send(32'h1C000480, 1, 1, 0, 1, 32'h1C000500, 1, 1, 32'h1C000500, 5'd3, 0);
      exp_q.push_back(mk(32'h1C000480, 5'd3, 0, 0, 0, 1, 0, 1, 32'h1C000500, 1, 0, 0, 32'h0));

      // Targets differing only in bits [1:0] are not a target error.
      send(32'h1C000504, 1, 0, 0, 1, 32'h1C000600, 1, 1, 32'h1C000603, 5'd9, 0);
      exp_q.push_back(mk(32'h1C000504, 5'd9, 0, 0, 0, 1, 0, 1, 32'h1C000600, 0, 0, 0, 32'h0));

      // False hit at the top of the address space; pc+4 wraps to 0.
      send(32'hFFFFFFFC, 0, 0, 0, 0, 32'h0, 1, 1, 32'h1C000000, 5'd12, 0);
      exp_q.push_back(mk(32'hFFFFFFFC, 5'd12, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0));

      // Flush in SQUASH with a matching, mispredicting input: dropped, back to IDLE.
      send(32'h00000000, 1, 0, 0, 1, 32'h1C000A00, 1, 0, 32'h0, 5'd1, 1);
      send(32'h1C000700, 1, 0, 0, 0, 32'h1C000704, 1, 0, 32'h1C000780, 5'd5, 0);
      exp_q.push_back(mk(32'h1C000700, 5'd5, 0, 0, 0, 1, 0, 0, 32'h1C000704, 0, 0, 0, 32'h0));

      // Return with no other command still raises operate_en.
      send(32'h1C000800, 1, 0, 1, 0, 32'h1C000900, 0, 0, 32'h0, 5'd0, 0);
      exp_q.push_back(mk(32'h1C000800, 5'd0, 0, 0, 0, 0, 0, 0, 32'h1C000900, 0, 1, 0, 32'h0));

      // Not-taken branch without a hit produces nothing.
      send(32'h1C000804, 1, 0, 0, 0, 32'h1C000900, 0, 0, 32'h0, 5'd0, 0);

      // False hit predicted not-taken: delete without redirect.
      send(32'h1C000808, 0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 5'd2, 0);
      exp_q.push_back(mk(32'h1C000808, 5'd2, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0));

      // Not-taken prediction on a taken call.
      send(32'h1C00080C, 1, 1, 0, 1, 32'h1C000A00, 1, 0, 32'h1C000A00, 5'd4, 0);
      exp_q.push_back(mk(32'h1C00080C, 5'd4, 0, 0, 1, 0, 0, 1, 32'h1C000A00, 1, 0, 1, 32'h1C000A00));

      // Reset mid-SQUASH; the following unrelated pc must be processed.
      @(negedge clk);
      reset = 1'b1; res_valid = 1'b1; res_pc = 32'h1C000A00;
      send(32'h1C000B00, 1, 0, 0, 1, 32'h1C000C00, 1, 1, 32'h1C000C00, 5'd6, 0);
      reset = 1'b0;
      exp_q.push_back(mk(32'h1C000B00, 5'd6, 0, 0, 0, 1, 0, 1, 32'h1C000C00, 0, 0, 0, 32'h0));

      send(32'h1C000B04, 1, 0, 0, 1, 32'h1C000D00, 0, 0, 32'h0, 5'd8, 0);
      exp_q.push_back(mk(32'h1C000B04, 5'd0, 1, 0, 0, 0, 0, 1, 32'h1C000D00, 0, 0, 1, 32'h1C000D00));

      idle(4);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_cmds: got %0d unconsumed expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
